// File: rtl/mult_seq_control.sv
// -----------------------------------------------------------------------------
// mult_seq_control
// Control FSM for the signed shift-add multiplier datapath (X:A:B registers,
// 9-bit adder/subtractor, switch input SW). One multiplication per Run
// request: clear X/A, then N_BITS add-then-shift pairs (the final conditional
// operation is a subtract, since the multiplier MSB carries negative weight),
// then hold the product until Run is released.
//
// Ports:
//   Clk           in  system clock, rising-edge active
//   Reset         in  asynchronous, active-high; forces IDLE and zero outputs
//   Run           in  level multiply request
//   ClearA_LoadB  in  clear X/A and load B from SW (honoured only in IDLE)
//   M             in  current LSB of B (multiplier bit under examination)
//   Clr_XA        out clear X and A on the next edge
//   Ld_B          out load B from SW on the next edge
//   Add           out load A/X with A+SW
//   Sub           out load A/X with A-SW
//   Shift         out arithmetic right shift of X:A:B
//   Busy          out high from CLR through the last SHIFT
//   Done          out high in HALT (product valid in A:B)
// -----------------------------------------------------------------------------
module mult_seq_control #(
    parameter int N_BITS = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clr_XA,
    output logic Ld_B,
    output logic Add,
    output logic Sub,
    output logic Shift,
    output logic Busy,
    output logic Done
);

    localparam int CW = $clog2(N_BITS) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N_BITS - 1);
    localparam logic [CW-1:0] ALL_STEPS = CW'(N_BITS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_cnt_inc;

    logic w_clr_xa;
    logic w_ld_b;
    logic w_add;
    logic w_sub;
    logic w_shift;
    logic w_busy;
    logic w_done;

    assign w_cnt_inc = r_cnt + CW'(1);

    // State and bit-counter registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, counter and raw (Mealy) enable decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clr_xa    = 1'b0;
        w_ld_b      = 1'b0;
        w_add       = 1'b0;
        w_sub       = 1'b0;
        w_shift     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Run wins over ClearA_LoadB: no load/clear when both are up.
                if (Run) begin
                    w_state_nxt = S_CLR;
                    w_cnt_nxt   = '0;
                end else if (ClearA_LoadB) begin
                    w_ld_b   = 1'b1;
                    w_clr_xa = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CLR: begin
                w_clr_xa    = 1'b1;
                w_busy      = 1'b1;
                w_state_nxt = S_ADD;
            end
            S_ADD: begin
                w_busy = 1'b1;
                // Last multiplier bit is the sign bit: subtract instead of add.
                if (r_cnt == LAST_STEP) begin
                    w_sub = M;
                end else begin
                    w_add = M;
                end
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                w_shift   = 1'b1;
                w_busy    = 1'b1;
                w_cnt_nxt = w_cnt_inc;
                if (w_cnt_inc == ALL_STEPS) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_state_nxt = S_ADD;
                end
            end
            S_HALT: begin
                w_done = 1'b1;
                // Run must be seen low before another multiplication can start.
                if (Run) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output gating: Reset kills every enable immediately, including the
    // IDLE-state Ld_B/Clr_XA that would otherwise follow ClearA_LoadB.
    always_comb begin
        if (Reset) begin
            Clr_XA = 1'b0;
            Ld_B   = 1'b0;
            Add    = 1'b0;
            Sub    = 1'b0;
            Shift  = 1'b0;
            Busy   = 1'b0;
            Done   = 1'b0;
        end else begin
            Clr_XA = w_clr_xa;
            Ld_B   = w_ld_b;
            Add    = w_add;
            Sub    = w_sub;
            Shift  = w_shift;
            Busy   = w_busy;
            Done   = w_done;
        end
    end

endmodule

// File: tb/tb_mult_seq_control.sv
module tb_mult_seq_control;

    localparam int N      = 8;
    localparam int P_IDLE = -1;
    localparam int P_HALT = 2 * N + 1;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic Run = 1'b0;
    logic ClearA_LoadB = 1'b0;
    logic M = 1'b0;
    logic Clr_XA, Ld_B, Add, Sub, Shift, Busy, Done;

    int tests = 0;
    int fails = 0;
    int ph = P_IDLE;       // model: -1 idle, 0 clear, 1..2N add/shift, 2N+1 halt
    int cyc = 0;
    logic [6:0] sb[$];     // expected {Clr_XA,Ld_B,Add,Sub,Shift,Busy,Done}

    mult_seq_control #(.N_BITS(N)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
        .Clr_XA(Clr_XA), .Ld_B(Ld_B), .Add(Add), .Sub(Sub), .Shift(Shift),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    // Expected outputs for the current cycle, from the cycle index within a multiplication
    function automatic logic [6:0] model_out(int p, logic run, logic clb, logic m, logic rst);
        int step;
        if (rst) return 7'b0000000;
        if (p == P_IDLE) begin
            if (run) return 7'b0000000;
            if (clb) return 7'b1100000;
            return 7'b0000000;
        end
        if (p == 0) return 7'b1000010;
        if (p == P_HALT) return 7'b0000001;
        if (p % 2 == 1) begin
            step = (p - 1) / 2;
            if (step == N - 1) return {3'b000, m, 3'b010};
            return {2'b00, m, 4'b0010};
        end
        return 7'b0000110;
    endfunction

    function automatic int model_next(int p, logic run, logic rst);
        if (rst) return P_IDLE;
        if (p == P_IDLE) return run ? 0 : P_IDLE;
        if (p == P_HALT) return run ? P_HALT : P_IDLE;
        return p + 1;
    endfunction

    // Multiplier bit from a pattern when the model is in an ADD cycle, random otherwise
    function automatic logic pick_m(logic [15:0] pat, int p);
        logic [31:0] r;
        if (p >= 1 && p < P_HALT && (p % 2 == 1)) return pat[(p - 1) / 2];
        r = $urandom;
        return r[0];
    endfunction

    task automatic drive(input logic run, input logic clb, input logic m, input logic rst);
        @(negedge Clk);
        Run = run;
        ClearA_LoadB = clb;
        M = m;
        Reset = rst;
        sb.push_back(model_out(ph, run, clb, m, rst));
        ph = model_next(ph, run, rst);
    endtask

    task automatic mult(input logic [15:0] pat, input int hold);
        int guard;
        for (int i = 0; i < hold; i++) drive(1'b1, 1'b0, pick_m(pat, ph), 1'b0);
        guard = 0;
        while (ph != P_IDLE && guard < 100) begin
            drive(1'b0, 1'b0, pick_m(pat, ph), 1'b0);
            guard++;
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against the scoreboard; also check Busy length
    int busy_len = 0;
    logic prev_busy = 1'b0;
    initial begin
        logic [6:0] got;
        logic [6:0] exp;
        forever begin
            @(negedge Clk);
            #3;
            cyc++;
            got = {Clr_XA, Ld_B, Add, Sub, Shift, Busy, Done};
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                tests++;
                if (got !== exp) begin
                    fails++;
                    $display("FAIL outs cyc=%0d got=%b exp=%b (Clr,LdB,Add,Sub,Sh,Busy,Done)", cyc, got, exp);
                end
            end
            if (Busy === 1'b1) busy_len++;
            if (prev_busy && Busy !== 1'b1) begin
                if (Done === 1'b1) begin
                    tests++;
                    if (busy_len != 2 * N + 1) begin
                        fails++;
                        $display("FAIL busy_len got=%0d exp=%0d", busy_len, 2 * N + 1);
                    end
                end
                busy_len = 0;
            end
            if (Busy !== 1'b1) busy_len = 0;
            prev_busy = (Busy === 1'b1);
        end
    end

    initial begin
        logic [31:0] r;
        // 1: reset with Run and ClearA_LoadB high, then Run starts immediately
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        mult(16'h00FD, 1);
        // 2: load requests in idle
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        // 3: B = 0xFD
        mult(16'h00FD, 1);
        // 4: Run held 40 cycles, then back-to-back restart
        mult(16'h00A5, 40);
        mult(16'h005A, 1);
        // 5: no add/sub, then a single sub on the sign bit
        mult(16'h0000, 1);
        mult(16'h0080, 1);
        // 6: reset during 4th SHIFT, then a clean multiplication
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int g = 0; g < 20 && ph != 8; g++) drive(1'b0, 1'b1, pick_m(16'h00FF, ph), 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        mult(16'h00FF, 1);
        // Random traffic
        for (int i = 0; i < 800; i++) begin
            r = $urandom;
            drive(r[1:0] == 2'b00, r[3:2] == 2'b00, r[4], r[15:8] == 8'h00);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        #4;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain got=%0d exp=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
